// File: rtl/rst_syn_pkg.sv
// Shared reset constants for every clock domain's reset conditioner
// and for the logic that consumes the conditioned reset.
package rst_syn_pkg;

   localparam int   RST_SYN_DEFAULT_STAGES = 2;
   localparam logic RST_ACTIVE             = 1'b1;

endpackage

// File: rtl/rst_syn_if.sv
// Conditioned reset as seen by a clock domain's reset tree.
// The conditioner side drives it; consumers only sample it.
interface rst_syn_if;
   import rst_syn_pkg::*;

   logic sync_rst;

   modport master (output sync_rst);
   modport slave  (input  sync_rst);

endinterface

// File: rtl/rst_syn.sv
// Reset conditioner: asserts on the first edge sampling RST high and
// releases NUM_STAGE edges after RST is sampled low.
module rst_syn
   import rst_syn_pkg::*;
#(
   parameter int NUM_STAGE = RST_SYN_DEFAULT_STAGES
) (
   input  logic CLK,
   input  logic RST,
   output logic SYNC_RST
);

   if (NUM_STAGE < 1) begin : g_bad_stage
      $fatal(1, "rst_syn: NUM_STAGE must be >= 1");
   end

   // Kept as discrete flops so tools neither merge nor retime the chain.
   (* keep = "true", dont_retime = "true", shreg_extract = "no" *)
   logic [NUM_STAGE-1:0] sync_q;
   logic [NUM_STAGE-1:0] shift_d;

   if (NUM_STAGE == 1) begin : g_one
      assign shift_d = '0;
   end else begin : g_many
      assign shift_d = {sync_q[NUM_STAGE-2:0], 1'b0};
   end

   always_ff @(posedge CLK) begin
      if (RST == RST_ACTIVE) begin
         sync_q <= '1;
      end else begin
         sync_q <= shift_d;
      end
   end

   assign SYNC_RST = sync_q[NUM_STAGE-1];

   a_rise_on_rst: assert property (
      @(posedge CLK) $rose(SYNC_RST) |-> $past(RST)
   ) else $error("rst_syn: SYNC_RST rose without RST sampled high");

   // Each of the last NUM_STAGE samples before a fall must be low.
   for (genvar i = 1; i <= NUM_STAGE; i++) begin : g_fall_chk
      a_fall_after_lows: assert property (
         @(posedge CLK) $fell(SYNC_RST) |-> !$past(RST, i)
      ) else $error("rst_syn: SYNC_RST fell too early");
   end

endmodule

// File: tb/tb_rst_syn.sv
// Scoreboarded bench for rst_syn at NUM_STAGE = 1..4.
module tb_rst_syn;
   import rst_syn_pkg::*;

   localparam int NV = 35;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] sr;
   logic [3:0] got;

   always #5 clk = ~clk;

   rst_syn_if sr_if ();

   rst_syn #(.NUM_STAGE(1)) u_s1 (.CLK(clk), .RST(rst), .SYNC_RST(sr[0]));
   rst_syn #(.NUM_STAGE(2)) u_s2 (.CLK(clk), .RST(rst), .SYNC_RST(sr[1]));
   rst_syn #(.NUM_STAGE(3)) u_s3 (.CLK(clk), .RST(rst), .SYNC_RST(sr[2]));
   rst_syn #(.NUM_STAGE(4)) u_s4 (.CLK(clk), .RST(rst), .SYNC_RST(sr[3]));

   assign sr_if.sync_rst = sr[1];
   assign got = {sr[3], sr[2], sr_if.sync_rst, sr[0]};

   // RST level sampled at edge k (edges at 5, 15, 25, ... ns).
   int rst_v [NV] = '{
      0, 0, 1, 1, 1, 1, 1, 1, 1, 1,
      1, 1, 0, 0, 0, 0, 1, 0, 0, 0,
      1, 0, 1, 0, 0, 0, 0, 0, 0, 0,
      1, 1, 0, 0, 0
   };
   // Hand-computed SYNC_RST after edge k for NUM_STAGE=2 (2 = undefined).
   int e2_v [NV] = '{
      2, 0, 1, 1, 1, 1, 1, 1, 1, 1,
      1, 1, 1, 0, 0, 0, 1, 1, 0, 0,
      1, 1, 1, 1, 0, 0, 0, 0, 0, 0,
      1, 1, 1, 0, 0
   };

   typedef struct {
      int         k;
      logic [3:0] known;
      logic [3:0] exp;
   } exp_t;

   exp_t q [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   since [4] = '{0, 0, 0, 0};
   bit   high_seen [4] = '{0, 0, 0, 0};

   task automatic push_exp(input int k);
      exp_t e;
      e.k = k;
      e.known = '0;
      e.exp = '0;
      for (int i = 0; i < 4; i++) begin
         if (rst_v[k] != 0) begin
            since[i] = 0;
            high_seen[i] = 1'b1;
         end else begin
            since[i]++;
         end
         if (i == 1) begin
            e.known[i] = (e2_v[k] != 2);
            e.exp[i] = (e2_v[k] == 1);
         end else begin
            e.known[i] = high_seen[i] || (since[i] >= i + 1);
            e.exp[i] = (since[i] < i + 1);
         end
      end
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            for (int i = 0; i < 4; i++) begin
               if (e.known[i]) begin
                  n_cmp++;
                  if (got[i] !== e.exp[i]) begin
                     n_bad++;
                     $display("FAIL sync_rst N=%0d edge %0d: got %b want %b",
                              i + 1, e.k, got[i], e.exp[i]);
                  end
               end
            end
         end
      end
   end

   initial begin : stimulus
      int budget;
      rst = 1'b0;
      push_exp(0);
      for (int k = 1; k < NV; k++) begin
         @(posedge clk);
         #3;
         rst = (rst_v[k] != 0);
         push_exp(k);
      end
      budget = 10;
      while (q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
